ascon_perm_ctrl: RTL and testbench

//  Iterative Ascon permutation engine. Runs p^N (N = 1..12) on a 320-bit state, one round per clock.

---
 rtl/ascon_pkg.sv | 79 +++++++
 rtl/ascon_round.sv | 45 ++++
 rtl/ascon_perm_ctrl.sv | 116 +++++++++++
 tb/tb_ascon_perm_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Ascon permutation shared definitions: state layout, round constants, rotations, S-box, FSM encoding.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
//
// Contents: state_t (320-bit state), rnd_t (round counter), x0..x4 word offsets
// (x0 is the most significant word), round_const(), ror64(), sbox5(), fsm_e.
package ascon_pkg;

  localparam int MAX_ROUNDS = 12;
  localparam int CNT_W      = 4;
  localparam int WORD_W     = 64;
  localparam int STATE_W    = 5 * WORD_W;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [CNT_W-1:0]   rnd_t;

  // LSB position of each 64-bit word inside the state vector
  localparam int X0_LSB = 4 * WORD_W;
  localparam int X1_LSB = 3 * WORD_W;
  localparam int X2_LSB = 2 * WORD_W;
  localparam int X3_LSB = 1 * WORD_W;
  localparam int X4_LSB = 0;

  // Linear diffusion rotation amounts (two per word)
  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_DONE = 2'd2
  } fsm_e;

  // c_i = ((15-i) << 4) | i, i.e. the two nibbles {15-i, i}
  function automatic logic [7:0] round_const(input rnd_t i);
    logic [3:0] hi;
    hi = 4'hF - i;
    return {hi, i};
  endfunction

  function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // One bit column through the 5-bit S-box; bit k of x/result is word xk
  function automatic logic [4:0] sbox5(input logic [4:0] x);
    logic a0, a1, a2, a3, a4;
    logic t0, t1, t2, t3, t4;
    a0 = x[0] ^ x[4];
    a1 = x[1];
    a2 = x[2] ^ x[1];
    a3 = x[3];
    a4 = x[4] ^ x[3];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    return {a4, a3, a2, a1, a0};
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round: constant addition, 64-column substitution layer, linear diffusion.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
//
// Ports: state_i (320b state in), round_i (round index i selecting the constant),
//        state_o (320b state after the round).
module ascon_round
  import ascon_pkg::*;
(
  input  state_t state_i,
  input  rnd_t   round_i,
  output state_t state_o
);

  logic [WORD_W-1:0] a0, a1, a2, a3, a4;   // after constant addition
  logic [WORD_W-1:0] s0, s1, s2, s3, s4;   // after substitution
  logic [WORD_W-1:0] l0, l1, l2, l3, l4;   // after diffusion

  always_comb begin
    a0 = state_i[X0_LSB +: WORD_W];
    a1 = state_i[X1_LSB +: WORD_W];
    a2 = state_i[X2_LSB +: WORD_W] ^ {{(WORD_W-8){1'b0}}, round_const(round_i)};
    a3 = state_i[X3_LSB +: WORD_W];
    a4 = state_i[X4_LSB +: WORD_W];
  end

  for (genvar j = 0; j < WORD_W; j++) begin : g_col
    logic [4:0] col_out;
    assign col_out = sbox5({a4[j], a3[j], a2[j], a1[j], a0[j]});
    assign s0[j] = col_out[0];
    assign s1[j] = col_out[1];
    assign s2[j] = col_out[2];
    assign s3[j] = col_out[3];
    assign s4[j] = col_out[4];
  end

  assign l0 = s0 ^ ror64(s0, ROT_X0_A) ^ ror64(s0, ROT_X0_B);
  assign l1 = s1 ^ ror64(s1, ROT_X1_A) ^ ror64(s1, ROT_X1_B);
  assign l2 = s2 ^ ror64(s2, ROT_X2_A) ^ ror64(s2, ROT_X2_B);
  assign l3 = s3 ^ ror64(s3, ROT_X3_A) ^ ror64(s3, ROT_X3_B);
  assign l4 = s4 ^ ror64(s4, ROT_X4_A) ^ ror64(s4, ROT_X4_B);

  assign state_o = {l0, l1, l2, l3, l4};

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon permutation p^N (N=1..12, N>12 clamps to 12, N=0 is identity), one round per clock.
// Latency: start accepted at edge k -> done_o high in cycle k+N+1 (k+ceil(N/2)+1 when unrolled).
// Backpressure: start_i accepted only while ready_o=1; starts during RUN/DONE are dropped, never queued.
//
// Ports: clk, rst (async, active-high); start_i/rounds_i/state_i request; ready_o, busy_o,
//        done_o (1-cycle pulse); state_o (working state, stable from done_o to next accept); round_o.
// Build option: ASCON_PERM_UNROLL2_EN -> two cascaded round stages per cycle.
module ascon_perm_ctrl
  import ascon_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [319:0] state_o,
  output logic [3:0]   round_o
);

  fsm_e   fsm_q, fsm_d;
  state_t state_q, state_d;
  rnd_t   cnt_q, cnt_d;

  rnd_t   n_eff;
  state_t stage0_out;
  state_t round_res;

  assign n_eff = (rounds_i > rnd_t'(MAX_ROUNDS)) ? rnd_t'(MAX_ROUNDS) : rounds_i;

  ascon_round u_round0 (
    .state_i (state_q),
    .round_i (cnt_q),
    .state_o (stage0_out)
  );

`ifdef ASCON_PERM_UNROLL2_EN
  localparam rnd_t CNT_STEP = rnd_t'(2);
  // Any counter value >= 10 completes the schedule this cycle
  localparam rnd_t LAST_CNT = rnd_t'(MAX_ROUNDS - 2);

  state_t stage1_out;
  rnd_t   round1;

  assign round1 = cnt_q + rnd_t'(1);

  ascon_round u_round1 (
    .state_i (stage0_out),
    .round_i (round1),
    .state_o (stage1_out)
  );

  // Odd N leaves the counter on 11 for the last cycle: only round 11 remains
  assign round_res = (cnt_q == rnd_t'(MAX_ROUNDS - 1)) ? stage0_out : stage1_out;
`else
  localparam rnd_t CNT_STEP = rnd_t'(1);
  localparam rnd_t LAST_CNT = rnd_t'(MAX_ROUNDS - 1);

  assign round_res = stage0_out;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= FSM_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_IDLE: if (start_i) fsm_d = (n_eff == '0) ? FSM_DONE : FSM_RUN;
      FSM_RUN:  if (cnt_q >= LAST_CNT) fsm_d = FSM_DONE;
      FSM_DONE: fsm_d = FSM_IDLE;
      default:  fsm_d = FSM_IDLE;
    endcase
  end

  // Datapath: load on accept, advance one (or two) rounds per RUN cycle, hold otherwise
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      FSM_IDLE: begin
        if (start_i) begin
          state_d = state_i;
          cnt_d   = rnd_t'(MAX_ROUNDS) - n_eff;
        end
      end
      FSM_RUN: begin
        state_d = round_res;
        cnt_d   = cnt_q + CNT_STEP;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    ready_o = (fsm_q == FSM_IDLE);
    busy_o  = (fsm_q == FSM_RUN);
    done_o  = (fsm_q == FSM_DONE);
    state_o = state_q;
    round_o = cnt_q;
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: vector table, random runs against a word-level model,
// plus hand sequences for reset abort and held-start handshake.
module tb_ascon_perm_ctrl;

`ifdef ASCON_PERM_UNROLL2_EN
  localparam bit UNR = 1'b1;
`else
  localparam bit UNR = 1'b0;
`endif
  localparam int STEP = UNR ? 2 : 1;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [3:0]   rounds_i;
  logic [319:0] state_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [319:0] state_o;
  logic [3:0]   round_o;

  int checks;
  int failures;

  ascon_perm_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .rounds_i (rounds_i),
    .state_i  (state_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .state_o  (state_o),
    .round_o  (round_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (64-bit word arithmetic) ----------------
  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    int nn;
    nn = (n > 12) ? 12 : n;
    {x0, x1, x2, x3, x4} = s;
    for (int i = 12 - nn; i < 12; i++) begin
      x2 = x2 ^ 64'((15 - i) * 16 + i);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ rr(x0, 19) ^ rr(x0, 28);
      x1 = x1 ^ rr(x1, 61) ^ rr(x1, 39);
      x2 = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
      x3 = x3 ^ rr(x3, 10) ^ rr(x3, 17);
      x4 = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // One full transaction; call right after an edge (+#1) with the DUT idle
  task automatic run_perm(input logic [3:0] n, input logic [319:0] s,
                          input int exp_lat, input int exp_first);
    logic [319:0] exp_s;
    int e_done;
    e_done = exp_lat - 1;
    exp_s  = model_perm(s, int'(n));
    chk("ready_before", 320'(ready_o), 320'(1));
    start_i  = 1'b1;
    rounds_i = n;
    state_i  = s;
    @(posedge clk); #1;
    start_i = 1'b0;
    state_i = rand320();
    for (int e = 0; e <= e_done; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      chk("done_timing", 320'(done_o), 320'(e == e_done));
      if (e < e_done) begin
        chk("busy_o", 320'(busy_o), 320'(1));
        chk("round_o", 320'(round_o), 320'(exp_first + STEP * e));
      end
    end
    chk("state_o", state_o, exp_s);
    @(posedge clk); #1;
    chk("ready_after", 320'(ready_o), 320'(1));
    chk("done_pulse", 320'(done_o), 320'(0));
    chk("state_hold", state_o, exp_s);
  endtask

  typedef struct {
    logic [3:0]   n;
    logic [319:0] s;
    int           lat;
    int           first;
  } vec_t;

  vec_t vecs[6];
  logic [319:0] iv_state;
  logic [319:0] sv[13];

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start_i = 1'b0; rounds_i = '0; state_i = '0;
    iv_state = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                64'h0f0e0d0c0b0a0908, 64'h0706050403020100};

    // Reset state
    #2;
    chk("rst_ready", 320'(ready_o), 320'(1));
    chk("rst_busy", 320'(busy_o), 320'(0));
    chk("rst_done", 320'(done_o), 320'(0));
    chk("rst_state", state_o, 320'(0));
    chk("rst_round", 320'(round_o), 320'(0));
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Table: p12(0), p6/p8 on IV state, N=0 identity, N=15 clamp, N=1
    vecs[0] = '{n: 4'd12, s: '0,       lat: UNR ? 7 : 13, first: 0};
    vecs[1] = '{n: 4'd6,  s: iv_state, lat: UNR ? 4 : 7,  first: 6};
    vecs[2] = '{n: 4'd8,  s: iv_state, lat: UNR ? 5 : 9,  first: 4};
    vecs[3] = '{n: 4'd0,  s: iv_state, lat: 1,            first: 12};
    vecs[4] = '{n: 4'd15, s: iv_state, lat: UNR ? 7 : 13, first: 0};
    vecs[5] = '{n: 4'd1,  s: iv_state, lat: 2,            first: 11};
    for (int v = 0; v < 6; v++) run_perm(vecs[v].n, vecs[v].s, vecs[v].lat, vecs[v].first);

    // Randomized runs against the model
    for (int r = 0; r < 16; r++) begin
      int n, ne;
      n  = $urandom_range(0, 15);
      ne = (n > 12) ? 12 : n;
      run_perm(4'(n), rand320(), UNR ? (ne + 1) / 2 + 1 : ne + 1, 12 - ne);
    end

    // Reset mid-run: abort after 5 rounds, no done pulse afterwards
    start_i = 1'b1; rounds_i = 4'd12; state_i = rand320();
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_ready", 320'(ready_o), 320'(1));
    chk("abort_busy", 320'(busy_o), 320'(0));
    chk("abort_state", state_o, 320'(0));
    chk("abort_round", 320'(round_o), 320'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      chk("abort_no_done", 320'(done_o), 320'(0));
      @(posedge clk); #1;
    end
    chk("abort_idle", 320'(ready_o), 320'(1));

    // Held start with N=1: accepted every 3 cycles, intermediate starts ignored
    for (int k = 0; k < 13; k++) sv[k] = rand320();
    start_i = 1'b1; rounds_i = 4'd1; state_i = sv[0];
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      chk("hs_done", 320'(done_o), 320'((e % 3) == 1));
      chk("hs_ready", 320'(ready_o), 320'((e % 3) == 2));
      if ((e % 3) == 1) chk("hs_state", state_o, model_perm(sv[e-1], 1));
      if ((e % 3) == 2) chk("hs_stable", state_o, model_perm(sv[e-2], 1));
      state_i = sv[e+1];
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("hs_end_idle", 320'(ready_o), 320'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
